// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: times enemy spawns, picks a free slot round-robin, counts kills/waves, latches game over.
// Latency: spawn_req rises interval+1 cycles after WAIT entry; kill/wave counters update the cycle after kill_pulse.
// Backpressure: spawn_req and its fields hold until spawn_ack; slot_over drops spawn_req combinationally.
// Optional feature: define ANGLE_DEDUP_EN to resample angles that collide with a live enemy's angle.
module enemy_spawn_scheduler #(
  parameter int          NUM_SLOTS      = 4,
  parameter int unsigned BASE_INTERVAL  = 50000000,
  parameter int unsigned INTERVAL_STEP  = 5000000,
  parameter int unsigned MIN_INTERVAL   = 10000000,
  parameter int unsigned KILLS_PER_WAVE = 8,
  parameter int unsigned WAVE_T2        = 2,
  localparam int         SW             = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] slot_busy,
  input  logic [NUM_SLOTS-1:0] slot_over,
  input  logic [NUM_SLOTS-1:0] kill_pulse,
  input  logic [3:0]           rng_angle,
  input  logic [1:0]           rng_type,
  input  logic                 spawn_ack,
  output logic                 spawn_req,
  output logic [SW-1:0]        spawn_slot,
  output logic [3:0]           spawn_angle,
  output logic [1:0]           spawn_type,
  output logic [15:0]          kill_count,
  output logic [3:0]           wave,
  output logic                 game_over,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_PICK  = 3'd2;
  localparam logic [2:0] ST_ISSUE = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic [2:0]    state;
  logic [31:0]   wait_cnt;
  logic [31:0]   cur_interval;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] pick_slot;
  logic [SW-1:0] rr_next;
  logic [SW:0]   scan_idx;
  logic          pick_found;
  logic          accept_pick;
  logic          any_over;
  logic          counting;
  logic [3:0]    kill_pop;
  logic [16:0]   kill_sum;
  logic [7:0]    kill_since;
  logic [7:0]    since_sum;
  logic [1:0]    mapped_type;

  // Spawn interval for a wave level; the subtraction is guarded so it never wraps.
  function automatic logic [31:0] interval_for(input logic [3:0] w);
    logic [31:0] step_total;
    logic [31:0] diff;
    step_total = 32'(w) * INTERVAL_STEP;
    if (step_total >= BASE_INTERVAL) begin
      return MIN_INTERVAL;
    end
    diff = BASE_INTERVAL - step_total;
    return (diff < MIN_INTERVAL) ? MIN_INTERVAL : diff;
  endfunction

  assign any_over  = |slot_over;
  assign counting  = (state == ST_WAIT) || (state == ST_PICK) || (state == ST_ISSUE);
  assign state_dbg = state;
  // Request drops in the very cycle an enemy reaches the centre.
  assign spawn_req = (state == ST_ISSUE) && !any_over;

  assign kill_pop  = 4'($countones(kill_pulse));
  assign kill_sum  = {1'b0, kill_count} + 17'(kill_pop);
  assign since_sum = kill_since + 8'(kill_pop);
  assign rr_next   = (pick_slot == SW'(NUM_SLOTS - 1)) ? '0 : pick_slot + SW'(1);

  // Round-robin scan: first free slot at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_slot  = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      scan_idx = {1'b0, rr_ptr} + (SW+1)'(i);
      if (scan_idx >= (SW+1)'(NUM_SLOTS)) begin
        scan_idx = scan_idx - (SW+1)'(NUM_SLOTS);
      end
      if (!pick_found && !slot_busy[scan_idx[SW-1:0]]) begin
        pick_found = 1'b1;
        pick_slot  = scan_idx[SW-1:0];
      end
    end
  end

  // Type 3 is unused; type 2 is held back to type 1 on early waves.
  always_comb begin
    mapped_type = rng_type;
    if (rng_type == 2'd3) begin
      mapped_type = 2'd0;
    end else if ((rng_type == 2'd2) && (wave < 4'(WAVE_T2))) begin
      mapped_type = 2'd1;
    end
  end

`ifdef ANGLE_DEDUP_EN
  logic [3:0] slot_angle [NUM_SLOTS];
  logic [3:0] dedup_tries;
  logic       angle_clash;

  // Does the offered angle match any live enemy we spawned earlier?
  always_comb begin
    angle_clash = 1'b0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      if (slot_busy[SW'(j)] && (slot_angle[SW'(j)] == rng_angle)) begin
        angle_clash = 1'b1;
      end
    end
  end

  // After 15 rejected samples the 16th is taken regardless.
  assign accept_pick = pick_found && (!angle_clash || (dedup_tries == 4'd15));

  // Remember each slot's spawn angle and count resample attempts in PICK.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NUM_SLOTS; j++) begin
        slot_angle[SW'(j)] <= '0;
      end
      dedup_tries <= '0;
    end else if ((state == ST_PICK) && !any_over) begin
      if (accept_pick) begin
        slot_angle[pick_slot] <= rng_angle;
        dedup_tries           <= '0;
      end else if (pick_found) begin
        dedup_tries <= dedup_tries + 4'd1;
      end
    end
  end
`else
  assign accept_pick = pick_found;
`endif

  // Main sequencer: interval timer, slot pick, request handshake, game-over latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      cur_interval <= '0;
      rr_ptr       <= '0;
      spawn_slot   <= '0;
      spawn_angle  <= '0;
      spawn_type   <= '0;
      game_over    <= 1'b0;
    end else if ((state != ST_IDLE) && any_over) begin
      state     <= ST_OVER;
      game_over <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_WAIT;
            wait_cnt     <= '0;
            cur_interval <= interval_for(wave);
          end
        end
        ST_WAIT: begin
          if (wait_cnt + 32'd1 >= cur_interval) begin
            state    <= ST_PICK;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_PICK: begin
          if (accept_pick) begin
            state       <= ST_ISSUE;
            spawn_slot  <= pick_slot;
            spawn_angle <= rng_angle;
            spawn_type  <= mapped_type;
            rr_ptr      <= rr_next;
          end
        end
        ST_ISSUE: begin
          if (spawn_ack) begin
            state        <= ST_WAIT;
            wait_cnt     <= '0;
            cur_interval <= interval_for(wave);
          end
        end
        default: state <= ST_OVER;
      endcase
    end
  end

  // Kill tally and wave advance; frozen outside the active states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kill_count <= '0;
      wave       <= '0;
      kill_since <= '0;
    end else if (counting) begin
      kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      if (since_sum >= 8'(KILLS_PER_WAVE)) begin
        kill_since <= since_sum - 8'(KILLS_PER_WAVE);
        if (wave != 4'd15) begin
          wave <= wave + 4'd1;
        end
      end else begin
        kill_since <= since_sum;
      end
    end
  end

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Testbench for enemy_spawn_scheduler: directed scenarios plus randomized traffic against a reference model.
// Runs with BASE_INTERVAL=20, INTERVAL_STEP=4, MIN_INTERVAL=8, KILLS_PER_WAVE=2, four slots.
// Define ANGLE_DEDUP_EN for both files to exercise the angle resampling path.
module tb_enemy_spawn_scheduler;

  localparam int NS   = 4;
  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MINI = 8;
  localparam int KPW  = 2;
  localparam int WT2  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  slot_busy = '0;
  logic [3:0]  slot_over = '0;
  logic [3:0]  kill_pulse = '0;
  logic [3:0]  rng_angle = '0;
  logic [1:0]  rng_type = '0;
  logic        spawn_ack = 1'b0;
  logic        spawn_req;
  logic [1:0]  spawn_slot;
  logic [3:0]  spawn_angle;
  logic [1:0]  spawn_type;
  logic [15:0] kill_count;
  logic [3:0]  wave;
  logic        game_over;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  enemy_spawn_scheduler #(
    .NUM_SLOTS(NS), .BASE_INTERVAL(BASE), .INTERVAL_STEP(STEP),
    .MIN_INTERVAL(MINI), .KILLS_PER_WAVE(KPW), .WAVE_T2(WT2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .slot_busy(slot_busy),
    .slot_over(slot_over), .kill_pulse(kill_pulse), .rng_angle(rng_angle),
    .rng_type(rng_type), .spawn_ack(spawn_ack), .spawn_req(spawn_req),
    .spawn_slot(spawn_slot), .spawn_angle(spawn_angle), .spawn_type(spawn_type),
    .kill_count(kill_count), .wave(wave), .game_over(game_over), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_COUNTDOWN, M_SEEK, M_OFFER, M_DEAD} mphase_t;
  mphase_t m_ph;
  int m_left, m_rr, m_slot, m_angle, m_type, m_kills, m_wave, m_since;
  int m_go;

  function automatic int ref_interval(input int w);
    int v;
    v = BASE - w * STEP;
    return (v < MINI) ? MINI : v;
  endfunction

  function automatic int phase_code(input mphase_t p);
    case (p)
      M_IDLE:      return 0;
      M_COUNTDOWN: return 1;
      M_SEEK:      return 2;
      M_OFFER:     return 3;
      default:     return 4;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_left = 0; m_rr = 0; m_slot = 0; m_angle = 0; m_type = 0;
    m_kills = 0; m_wave = 0; m_since = 0; m_go = 0;
  endtask

  // One clock edge of the game rules, applied to the inputs present at that edge.
  task automatic model_step();
    int w0;
    int t;
    int s;
    bit found;
    w0 = m_wave;
    if (m_ph == M_COUNTDOWN || m_ph == M_SEEK || m_ph == M_OFFER) begin
      m_kills = m_kills + $countones(kill_pulse);
      if (m_kills > 65535) m_kills = 65535;
      m_since = m_since + $countones(kill_pulse);
      if (m_since >= KPW) begin
        m_since = m_since - KPW;
        if (m_wave < 15) m_wave = m_wave + 1;
      end
    end
    if (m_ph != M_IDLE && slot_over != 4'b0) begin
      m_ph = M_DEAD;
      m_go = 1;
    end else begin
      case (m_ph)
        M_IDLE: if (start) begin m_ph = M_COUNTDOWN; m_left = ref_interval(w0); end
        M_COUNTDOWN: begin
          m_left = m_left - 1;
          if (m_left == 0) m_ph = M_SEEK;
        end
        M_SEEK: begin
          found = 0;
          for (int k = 0; k < NS; k++) begin
            s = (m_rr + k) % NS;
            if (!found && !slot_busy[s[1:0]]) begin
              found = 1;
              m_slot = s;
            end
          end
          if (found) begin
            m_rr = (m_slot + 1) % NS;
            m_angle = int'(rng_angle);
            t = int'(rng_type);
            if (t == 3) t = 0;
            else if (t == 2 && w0 < WT2) t = 1;
            m_type = t;
            m_ph = M_OFFER;
          end
        end
        M_OFFER: if (spawn_ack) begin m_ph = M_COUNTDOWN; m_left = ref_interval(w0); end
        default: ;
      endcase
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({spawn_req, spawn_slot, spawn_angle, spawn_type, kill_count, wave, game_over, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%0b slot=%0d ang=%0d typ=%0d kills=%0d wave=%0d go=%0b st=%0d want all 0",
               spawn_req, spawn_slot, spawn_angle, spawn_type, kill_count, wave, game_over, state_dbg);
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL idle_without_start got %0d want 0", state_dbg); end
  endtask

  task automatic test_first_spawn();
    int n;
    slot_busy = 4'b0000; rng_angle = 4'd5; rng_type = 2'd3; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk); start = 1'b0;
    end while (!spawn_req && n < 100);
    checks++;
    if (n !== 22) begin errors++; $display("FAIL first_spawn_latency got %0d want 22", n); end
    checks++;
    if (spawn_slot !== 2'd0 || spawn_angle !== 4'd5 || spawn_type !== 2'd0 || state_dbg !== 3'd3) begin
      errors++;
      $display("FAIL first_spawn_fields got slot=%0d ang=%0d typ=%0d st=%0d want 0 5 0 3", spawn_slot, spawn_angle, spawn_type, state_dbg);
    end
    rng_angle = 4'd11; rng_type = 2'd2;
    repeat (3) cycle();
    checks++;
    if (spawn_req !== 1'b1 || spawn_angle !== 4'd5 || spawn_type !== 2'd0) begin
      errors++;
      $display("FAIL issue_hold got req=%0b ang=%0d typ=%0d want 1 5 0", spawn_req, spawn_angle, spawn_type);
    end
  endtask

  task automatic test_full_slots();
    int n;
    slot_busy = 4'b1111; spawn_ack = 1'b1;
    cycle();
    spawn_ack = 1'b0;
    checks++;
    if (spawn_req !== 1'b0 || state_dbg !== 3'd1) begin
      errors++; $display("FAIL ack_to_wait got req=%0b st=%0d want 0 1", spawn_req, state_dbg);
    end
    n = 0;
    while (state_dbg !== 3'd2 && n < 100) begin cycle(); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL reach_pick got timeout want state 2"); end
    repeat (5) cycle();
    checks++;
    if (state_dbg !== 3'd2 || spawn_req !== 1'b0) begin
      errors++; $display("FAIL pick_hold_full got st=%0d req=%0b want 2 0", state_dbg, spawn_req);
    end
    slot_busy = 4'b1011; rng_angle = 4'd3; rng_type = 2'd2;
    cycle();
    checks++;
    if (spawn_req !== 1'b1 || spawn_slot !== 2'd2 || spawn_angle !== 4'd3 || spawn_type !== 2'd1) begin
      errors++;
      $display("FAIL released_slot got req=%0b slot=%0d ang=%0d typ=%0d want 1 2 3 1", spawn_req, spawn_slot, spawn_angle, spawn_type);
    end
  endtask

  task automatic test_kills();
    int n;
    slot_busy = 4'b0000; spawn_ack = 1'b1; n = 0;
    @(posedge clk); n++; @(negedge clk); spawn_ack = 1'b0; kill_pulse = 4'b0011;
    @(posedge clk); n++; @(negedge clk); kill_pulse = 4'b0000;
    checks++;
    if (kill_count !== 16'd2 || wave !== 4'd1) begin
      errors++; $display("FAIL kill_wave got kills=%0d wave=%0d want 2 1", kill_count, wave);
    end
    while (!spawn_req && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    checks++;
    if (n !== 22) begin errors++; $display("FAIL interval_kept_mid_wait got %0d want 22", n); end
    checks++;
    if (spawn_slot !== 2'd3) begin errors++; $display("FAIL rr_after_slot2 got %0d want 3", spawn_slot); end
    spawn_ack = 1'b1; n = 0;
    do begin
      @(posedge clk); n++; @(negedge clk); spawn_ack = 1'b0;
    end while (!spawn_req && n < 100);
    checks++;
    if (n !== 18) begin errors++; $display("FAIL wave1_interval got %0d want 18", n); end
    checks++;
    if (spawn_slot !== 2'd0) begin errors++; $display("FAIL rr_wrap got %0d want 0", spawn_slot); end
  endtask

  task automatic test_game_over();
    slot_over = 4'b0010;
    #1;
    checks++;
    if (spawn_req !== 1'b0) begin errors++; $display("FAIL over_drops_req got %0b want 0", spawn_req); end
    cycle();
    slot_over = 4'b0000;
    checks++;
    if (game_over !== 1'b1 || state_dbg !== 3'd4) begin
      errors++; $display("FAIL over_latch got go=%0b st=%0d want 1 4", game_over, state_dbg);
    end
    kill_pulse = 4'b1111; spawn_ack = 1'b1; start = 1'b1;
    cycle();
    kill_pulse = 4'b0000; spawn_ack = 1'b0; start = 1'b0;
    cycle();
    checks++;
    if (kill_count !== 16'd2 || wave !== 4'd1 || state_dbg !== 3'd4 || game_over !== 1'b1 || spawn_req !== 1'b0) begin
      errors++;
      $display("FAIL over_frozen got kills=%0d wave=%0d st=%0d go=%0b req=%0b want 2 1 4 1 0",
               kill_count, wave, state_dbg, game_over, spawn_req);
    end
  endtask

  task automatic test_reset_mid_issue();
    int n;
    reset = 1'b0; cycle(); reset = 1'b1;
    slot_busy = 4'b0000; start = 1'b1; cycle(); start = 1'b0;
    kill_pulse = 4'b0100; cycle(); kill_pulse = 4'b0000;
    n = 0;
    while (!spawn_req && n < 100) begin cycle(); n++; end
    checks++;
    if (kill_count !== 16'd1 || spawn_req !== 1'b1) begin
      errors++; $display("FAIL pre_reset_issue got kills=%0d req=%0b want 1 1", kill_count, spawn_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (spawn_req !== 1'b0 || state_dbg !== 3'd0 || kill_count !== 16'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got req=%0b st=%0d kills=%0d go=%0b want 0 0 0 0", spawn_req, state_dbg, kill_count, game_over);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_dedup();
    int n;
    slot_busy = 4'b0000; rng_angle = 4'd7; rng_type = 2'd1; start = 1'b1;
    cycle(); start = 1'b0;
    n = 0;
    while (!spawn_req && n < 100) begin cycle(); n++; end
    checks++;
    if (spawn_req !== 1'b1 || spawn_slot !== 2'd0 || spawn_angle !== 4'd7) begin
      errors++; $display("FAIL dedup_first got req=%0b slot=%0d ang=%0d want 1 0 7", spawn_req, spawn_slot, spawn_angle);
    end
    slot_busy = 4'b0001; spawn_ack = 1'b1; cycle(); spawn_ack = 1'b0;
    n = 0;
    while (state_dbg !== 3'd2 && n < 100) begin cycle(); n++; end
    cycle();
`ifdef ANGLE_DEDUP_EN
    checks++;
    if (state_dbg !== 3'd2 || spawn_req !== 1'b0) begin
      errors++; $display("FAIL dedup_resample got st=%0d req=%0b want 2 0", state_dbg, spawn_req);
    end
    rng_angle = 4'd9;
    cycle();
    checks++;
    if (spawn_req !== 1'b1 || spawn_angle !== 4'd9 || spawn_slot !== 2'd1) begin
      errors++; $display("FAIL dedup_accept got req=%0b ang=%0d slot=%0d want 1 9 1", spawn_req, spawn_angle, spawn_slot);
    end
`else
    checks++;
    if (spawn_req !== 1'b1 || spawn_angle !== 4'd7 || spawn_slot !== 2'd1) begin
      errors++; $display("FAIL dup_angle_allowed got req=%0b ang=%0d slot=%0d want 1 7 1", spawn_req, spawn_angle, spawn_slot);
    end
`endif
    spawn_ack = 1'b0; slot_busy = 4'b0000;
  endtask

  // ---------------- randomized traffic vs model ----------------
  task automatic test_random();
    for (int ep = 0; ep < 4; ep++) begin
      reset = 1'b0; start = 1'b0; slot_busy = '0; slot_over = '0; kill_pulse = '0; spawn_ack = 1'b0;
      @(negedge clk);
      model_reset();
      reset = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
        start      = (cyc == 1) || ($urandom_range(0, 49) == 0);
        slot_busy  = 4'($urandom) & 4'($urandom);
        kill_pulse = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
        slot_over  = (ep >= 2 && cyc > 200 && $urandom_range(0, 299) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        spawn_ack  = 1'($urandom);
        rng_angle  = 4'($urandom);
        rng_type   = 2'($urandom);
        #1;
        checks++;
        if (int'(state_dbg) !== phase_code(m_ph)) begin
          errors++; $display("FAIL rand_state ep%0d cyc%0d got %0d want %0d", ep, cyc, state_dbg, phase_code(m_ph));
        end
        checks++;
        if (spawn_req !== ((m_ph == M_OFFER) && (slot_over == 4'b0000))) begin
          errors++; $display("FAIL rand_req ep%0d cyc%0d got %0b want %0b", ep, cyc, spawn_req, (m_ph == M_OFFER) && (slot_over == 4'b0000));
        end
        checks++;
        if (int'(kill_count) !== m_kills || int'(wave) !== m_wave || int'(game_over) !== m_go) begin
          errors++;
          $display("FAIL rand_counters ep%0d cyc%0d got kills=%0d wave=%0d go=%0b want %0d %0d %0d",
                   ep, cyc, kill_count, wave, game_over, m_kills, m_wave, m_go);
        end
        if (m_ph == M_OFFER) begin
          checks++;
          if (int'(spawn_slot) !== m_slot || int'(spawn_angle) !== m_angle || int'(spawn_type) !== m_type) begin
            errors++;
            $display("FAIL rand_fields ep%0d cyc%0d got slot=%0d ang=%0d typ=%0d want %0d %0d %0d",
                     ep, cyc, spawn_slot, spawn_angle, spawn_type, m_slot, m_angle, m_type);
          end
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_spawn();
    test_full_slots();
    test_kills();
    test_game_over();
    test_reset_mid_issue();
    test_dedup();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
